cola_vend_ctrl: RTL

COLA_VEND_CTRL -- requirements
Module: cola_vend_ctrl

---
 rtl/cola_vend_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/cola_vend_ctrl.sv
// Two-slot cola vending controller: per-slot coin holding registers, round-robin
// crediting, dispense handshake with timeout refund, and half-yuan change payout.
module cola_vend_ctrl #(
    parameter int PRICE   = 5,
    parameter int TIMEOUT = 1000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       slot0_one,
    input  logic       slot0_half,
    input  logic       slot1_one,
    input  logic       slot1_half,
    input  logic       pi_dispense_ack,
    output logic       po_dispense_req,
    output logic       po_change,
    output logic [3:0] po_credit,
    output logic       po_busy,
    output logic       po_fault,
    output logic       po_coin_drop
);

    localparam int              CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [4:0]      PRICE5    = 5'(PRICE);
    localparam logic [3:0]      PRICE4    = 4'(PRICE);
    localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DISPENSE,
        ST_CHANGE,
        ST_FAULT
    } state_t;

    state_t           state;
    logic [1:0]       coin0;
    logic [1:0]       coin1;
    logic [1:0]       pend0;
    logic [1:0]       pend1;
    logic             prio1;
    logic             can_grant;
    logic             grant0;
    logic             grant1;
    logic             drop0;
    logic             drop1;
    logic [1:0]       grant_val;
    logic [4:0]       sum;
    logic [CNT_W-1:0] tcnt;

    // A slot pulse is worth 2*one + half, which is exactly the bit pair {one, half}.
    assign coin0 = {slot0_one, slot0_half};
    assign coin1 = {slot1_one, slot1_half};

    // prio1 only flips when both slots contend, so uncontested grants keep the turn.
    always_comb begin
        can_grant = (state == ST_IDLE) || (state == ST_COLLECT);
        grant0    = can_grant && (pend0 != 2'd0) && ((pend1 == 2'd0) || !prio1);
        grant1    = can_grant && (pend1 != 2'd0) && !grant0;
        grant_val = grant0 ? pend0 : (grant1 ? pend1 : 2'd0);
        sum       = {1'b0, po_credit} + {3'b000, grant_val};
        drop0     = (coin0 != 2'd0) && (pend0 != 2'd0) && !grant0;
        drop1     = (coin1 != 2'd0) && (pend1 != 2'd0) && !grant1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pend0        <= 2'd0;
            pend1        <= 2'd0;
            prio1        <= 1'b0;
            po_coin_drop <= 1'b0;
        end else begin
            if (coin0 != 2'd0) begin
                if ((pend0 == 2'd0) || grant0) begin
                    pend0 <= coin0;
                end
            end else if (grant0) begin
                pend0 <= 2'd0;
            end

            if (coin1 != 2'd0) begin
                if ((pend1 == 2'd0) || grant1) begin
                    pend1 <= coin1;
                end
            end else if (grant1) begin
                pend1 <= 2'd0;
            end

            if (grant0 && (pend1 != 2'd0)) begin
                prio1 <= 1'b1;
            end else if (grant1 && (pend0 != 2'd0)) begin
                prio1 <= 1'b0;
            end

            po_coin_drop <= drop0 || drop1;
        end
    end

    // Main sequencer; every output is set alongside the state it belongs to.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state           <= ST_IDLE;
            po_credit       <= 4'd0;
            po_dispense_req <= 1'b0;
            po_change       <= 1'b0;
            po_busy         <= 1'b0;
            po_fault        <= 1'b0;
            tcnt            <= '0;
        end else begin
            po_fault <= 1'b0;
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (sum >= PRICE5) begin
                        state           <= ST_DISPENSE;
                        po_credit       <= 4'(sum - PRICE5);
                        po_dispense_req <= 1'b1;
                        po_busy         <= 1'b1;
                        tcnt            <= '0;
                    end else begin
                        po_credit <= sum[3:0];
                        state     <= (sum == 5'd0) ? ST_IDLE : ST_COLLECT;
                    end
                end

                ST_DISPENSE: begin
                    if (pi_dispense_ack) begin
                        po_dispense_req <= 1'b0;
                        tcnt            <= '0;
                        if (po_credit != 4'd0) begin
                            state <= ST_CHANGE;
                        end else begin
                            state   <= ST_IDLE;
                            po_busy <= 1'b0;
                        end
                    end else if (tcnt == TCNT_LAST) begin
                        // Motor never answered: refund the price on top of any remainder.
                        state           <= ST_FAULT;
                        po_dispense_req <= 1'b0;
                        po_credit       <= po_credit + PRICE4;
                        po_fault        <= 1'b1;
                        tcnt            <= '0;
                    end else begin
                        tcnt <= tcnt + CNT_W'(1);
                    end
                end

                ST_FAULT: begin
                    state <= ST_CHANGE;
                end

                ST_CHANGE: begin
                    if (po_change) begin
                        po_change <= 1'b0;
                    end else if (po_credit != 4'd0) begin
                        po_change <= 1'b1;
                        po_credit <= po_credit - 4'd1;
                    end else begin
                        state   <= ST_IDLE;
                        po_busy <= 1'b0;
                    end
                end

                default: begin
                    state           <= ST_IDLE;
                    po_credit       <= 4'd0;
                    po_dispense_req <= 1'b0;
                    po_change       <= 1'b0;
                    po_busy         <= 1'b0;
                    tcnt            <= '0;
                end
            endcase
        end
    end

endmodule
